dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of data and address buses.
REQ-002 Parameter DEPTH, default 16, number of words in the data memory; valid word addresses are 0..DEPTH-1.
REQ-003 clk  in  1  single clock; the only clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_req, m1_req  in  1 each  access request, held high until done.
REQ-006 m0_we, m1_we  in  1 each  1 = write, 0 = read; sampled with req.
REQ-007 m0_addr, m1_addr  in  DATA_W each  word address.
REQ-008 m0_wdata, m1_wdata  in  DATA_W each  write data.
REQ-009 m0_gnt, m1_gnt  out  1 each  one-cycle pulse: request accepted, memory access in progress.
REQ-010 m0_done, m1_done  out  1 each  one-cycle pulse: access complete.
REQ-011 m0_err, m1_err  out  1 each  valid with done: address out of range.
REQ-012 rdata  out  DATA_W  read result; valid with either done after a read.
REQ-013 mem_addr, mem_wdata  out  DATA_W each  memory address and write data.
REQ-014 mem_write, mem_read  out  1 each  memory write and read strobes.
REQ-015 mem_rdata  in  DATA_W  combinational read data from the memory.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-017 Transitions: IDLE->ACCESS when any req=1 at posedge; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-018 req SHALL be sampled only in IDLE; req in ACCESS and DONE is ignored. Throughput: at most one access per 3 cycles.
REQ-019 On IDLE->ACCESS the winner's we, addr and wdata SHALL be latched; later changes to those inputs SHALL have no effect on that access.
REQ-020 Single request: that requester wins.
REQ-021 Both requests: round-robin, the requester not granted last wins. The last-granted register resets to m1, so m0 wins the first tie.
REQ-022 In ACCESS: gnt of the winner =1; mem_addr and mem_wdata are driven from the latched values.
REQ-023 In ACCESS: mem_write = latched we; mem_read = !latched we. The memory commits writes on the negedge of the ACCESS cycle.
REQ-024 In ACCESS with latched addr >= DEPTH: mem_write=0 and mem_read=0.
REQ-025 At ACCESS->DONE, rdata SHALL register mem_rdata for an in-range read, and 0 for a write or an out-of-range access.
REQ-026 In DONE: done of the winner =1; err =1 if the address was out of range.
REQ-027 Latency: req sampled at edge N -> gnt in cycle N..N+1 -> done and rdata in cycle N+1..N+2.
REQ-028 All outputs SHALL come directly from registers; gnt and done are one-hot and never high together.
REQ-029 In IDLE and DONE: mem_write=0 and mem_read=0; mem_addr and mem_wdata hold their last values.
REQ-030 A requester SHALL drop or renew req on the edge ending DONE. A req still high in the following IDLE is treated as a new request.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE and clear all outputs to 0: gnt, done, err, rdata, mem_addr, mem_wdata, mem_write, mem_read.
REQ-032 Reset asserted mid-ACCESS before the negedge SHALL suppress the write (mem_write=0); the aborted access produces no done.
REQ-033 After reset deassertion, the first arbitration occurs at the first posedge with req high.

Structure
REQ-034 Package mips_mem_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), DEPTH_DEFAULT=16 and the requester index type.
REQ-035 Sub-module rr_arb2 SHALL be combinational: inputs req[1:0] and last; outputs a one-hot grant.

Verification
REQ-036 m0 write: addr=3, wdata=0xDEADBEEF -> m0_gnt in cycle 1, mem_write=1 with mem_addr=3, m0_done in cycle 2; then an m0 read of addr 3 -> rdata=0xDEADBEEF with m0_done.
REQ-037 m0 and m1 request simultaneously, held for 4 accesses -> grants m0, m1, m0, m1, each 3 cycles apart.
REQ-038 m1 read, addr=20 (DEPTH=16) -> mem_read=0 and mem_write=0 throughout; m1_done=1, m1_err=1, rdata=0.
REQ-039 m0 write to addr 5 with reset asserted mid-ACCESS before the negedge -> all outputs 0 at once, no done, memory word 5 unchanged.
REQ-040 m0 changes addr and wdata during ACCESS -> the write uses the values latched at grant.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types for the data-memory arbiter.
//   state_e   - arbiter FSM states
//   req_idx_t - requester index (0 = m0, 1 = m1)
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef logic req_idx_t;
    localparam int DEPTH_DEFAULT = 16;
    localparam req_idx_t REQ_M0 = 1'b0;
    localparam req_idx_t REQ_M1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
//   req  in  2  request per requester
//   last in  1  requester granted most recently
//   gnt  out 2  one-hot grant (zero when no request)
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] gnt
);
    // On a tie the requester that was not granted last wins.
    assign gnt[0] = req[0] & (~req[1] | (last == REQ_M1));
    assign gnt[1] = req[1] & (~req[0] | (last == REQ_M0));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data-memory arbiter, IDLE -> ACCESS -> DONE.
//   clk, reset            clock, async active-high reset
//   mN_req/we/addr/wdata  master requests (sampled in IDLE only)
//   mN_gnt/done/err       per-master grant, completion and range error pulses
//   rdata                 read result, valid with done
//   mem_*                 memory-side address, data and strobes; mem_rdata is combinational
module dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_done,
    output logic              m1_done,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    req_idx_t          last_q, last_d;
    logic              we_q, we_d;
    logic [1:0]        gnt_q, gnt_d, done_q, done_d, err_q, err_d, arb_gnt;
    logic [DATA_W-1:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d, mem_read_q, mem_read_d;
    req_idx_t          win;
    logic              sel_we, sel_ok, addr_ok;
    logic [DATA_W-1:0] sel_addr, sel_wdata;

    rr_arb2 u_arb (.req({m1_req, m0_req}), .last(last_q), .gnt(arb_gnt));

    assign win       = arb_gnt[1];
    assign sel_we    = win ? m1_we : m0_we;
    assign sel_addr  = win ? m1_addr : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;
    assign sel_ok    = sel_addr < DATA_W'(DEPTH);
    // mem_addr_q holds the latched address for the whole access.
    assign addr_ok   = mem_addr_q < DATA_W'(DEPTH);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        we_d        = we_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        case (state_q)
            IDLE: if (|arb_gnt) begin
                state_d     = ACCESS;
                last_d      = win;
                we_d        = sel_we;
                gnt_d       = arb_gnt;
                mem_addr_d  = sel_addr;
                mem_wdata_d = sel_wdata;
                mem_write_d = sel_we & sel_ok;
                mem_read_d  = ~sel_we & sel_ok;
            end
            ACCESS: begin
                state_d = DONE;
                done_d  = (last_q == REQ_M1) ? 2'b10 : 2'b01;
                err_d   = addr_ok ? 2'b00 : done_d;
                rdata_d = (~we_q & addr_ok) ? mem_rdata : '0;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= REQ_M1;
            we_q        <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            we_q        <= we_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign {m1_gnt, m0_gnt}   = gnt_q;
    assign {m1_done, m0_done} = done_q;
    assign {m1_err, m0_err}   = err_q;
    assign rdata              = rdata_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_write          = mem_write_q;
    assign mem_read           = mem_read_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [DW-1:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic mem_write, mem_read;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic mem_init;
    bit last_m1;
    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(int i);
        return DW'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    endfunction

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_write && mem_addr < DEPTH) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[3:0]] : '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic round(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit w, we, ok;
        logic [DW-1:0] a, d, exp_rd;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        @(posedge clk); #1;
        if (!r0 && !r1) begin
            check("idle", {m1_gnt, m0_gnt, m1_done, m0_done, mem_write, mem_read}, '0);
            @(negedge clk);
            return;
        end
        w = (r0 && r1) ? !last_m1 : r1;
        last_m1 = w;
        we = w ? w1 : w0;
        a = w ? a1 : a0;
        d = w ? d1 : d0;
        ok = a < DEPTH;
        exp_rd = (!we && ok) ? ref_mem[a[3:0]] : '0;
        if (we && ok) ref_mem[a[3:0]] = d;
        check("gnt", {m1_gnt, m0_gnt}, w ? 2 : 1);
        check("done_in_access", {m1_done, m0_done}, '0);
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, d);
        check("strobes", {mem_write, mem_read}, ok ? (we ? 2 : 1) : 0);
        @(negedge clk);
        // Disturb the inputs mid-access: the access must keep its latched values.
        m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
        m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
        @(posedge clk); #1;
        check("done", {m1_done, m0_done}, w ? 2 : 1);
        check("err", {m1_err, m0_err}, ok ? 0 : (w ? 2 : 1));
        check("rdata", rdata, exp_rd);
        check("gnt_in_done", {m1_gnt, m0_gnt, mem_write, mem_read}, '0);
        check("mem_addr_hold", mem_addr, a);
        @(negedge clk);
        @(posedge clk); #1;
        check("after_done", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, mem_write, mem_read}, '0);
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] old5;
        reset = 1'b1; mem_init = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        last_m1 = 1'b1;
        @(negedge clk); @(negedge clk);
        mem_init = 1'b0;
        check("reset_ctl", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, mem_write, mem_read}, '0);
        check("reset_rdata", rdata, '0);
        check("reset_addr", mem_addr, '0);
        check("reset_wdata", mem_wdata, '0);
        reset = 1'b0;
        // Simultaneous requests held for four accesses: m0, m1, m0, m1.
        for (int i = 0; i < 4; i++) round(1, 1, 0, 0, DW'(i), DW'(i + 4), '0, '0);
        // m0 write then read back.
        round(1, 0, 1, 0, 3, 0, 32'hDEAD_BEEF, 0);
        round(1, 0, 0, 0, 3, 0, 0, 0);
        // Out-of-range read by m1.
        round(0, 1, 0, 0, 0, 20, 0, 0);
        round(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-ACCESS before the negedge aborts a write to word 5.
        old5 = ref_mem[5];
        m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = ~old5;
        m1_req = 0;
        @(posedge clk); #1;
        check("rst_gnt", {m1_gnt, m0_gnt, mem_write}, 3'b011);
        reset = 1'b1;
        #1;
        check("rst_async_ctl", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, mem_write, mem_read}, '0);
        check("rst_async_bus", mem_addr | mem_wdata | rdata, '0);
        m0_req = 0;
        @(negedge clk);
        @(posedge clk); #1;
        check("rst_no_done", {m1_done, m0_done}, '0);
        @(negedge clk);
        reset = 1'b0;
        last_m1 = 1'b1;
        check("rst_mem5", mem[5], old5);
        round(1, 0, 0, 0, 5, 0, 0, 0);
        for (int n = 0; n < 200; n++) begin
            round(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  DW'($urandom_range(0, 23)), DW'($urandom_range(0, 23)), $urandom, $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
